// File: rtl/video_pkg.sv
// Shared types and helpers for the video output stage: fade states, CRAM word layout
// and the per-channel brightness scaler.
package video_pkg;

   localparam logic [4:0] FADE_MAX = 5'd16;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      STEP
   } fade_state_t;

   // CRAM word: mode bit 15, R 14:10, G 9:5, B 4:0
   typedef struct packed {
      logic       mode;
      logic [4:0] r;
      logic [4:0] g;
      logic [4:0] b;
   } cram_word_t;

   // (c * lvl) >> 4; lvl is 0..16, so the result never exceeds c
   function automatic logic [4:0] scale_ch(input logic [4:0] c, input logic [4:0] lvl);
      logic [9:0] p;
      p = 10'(c) * 10'(lvl);
      return 5'(p >> 4);
   endfunction

endpackage

// File: rtl/dpram.sv
// Simple dual-port RAM: port A write-only, port B registered read returning old data
// on a same-address collision.
module dpram #(
   parameter int unsigned DATAWIDTH = 16,
   parameter int unsigned ADDRWIDTH = 8
) (
   input  logic                 clk,
   input  logic                 we_a,
   input  logic [ADDRWIDTH-1:0] addr_a,
   input  logic [DATAWIDTH-1:0] data_a,
   input  logic [ADDRWIDTH-1:0] addr_b,
   output logic [DATAWIDTH-1:0] q_b
);

   localparam int unsigned DEPTH = 1 << ADDRWIDTH;

   logic [DATAWIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we_a) mem[addr_a] <= data_a;
   end

   always_ff @(posedge clk) begin
      q_b <= mem[addr_b];
   end

endmodule

// File: rtl/video_fade_ctrl.sv
// Frame-synchronous fade controller: steps the global brightness level toward
// black or full every (rate+1) frame ticks.
module video_fade_ctrl
   import video_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       fade_start,
   input  logic       fade_dir,
   input  logic [3:0] fade_rate,
   output logic       fade_busy,
   output logic [4:0] fade_level
);

   fade_state_t state_q, state_d;
   logic       dir_q, dir_d;
   logic [3:0] rate_q, rate_d;
   logic [3:0] cnt_q, cnt_d;
   logic [4:0] level_d;
   logic       at_target;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         dir_q      <= 1'b0;
         rate_q     <= '0;
         cnt_q      <= '0;
         fade_level <= FADE_MAX;
         fade_busy  <= 1'b0;
      end else begin
         state_q    <= state_d;
         dir_q      <= dir_d;
         rate_q     <= rate_d;
         cnt_q      <= cnt_d;
         fade_level <= level_d;
         fade_busy  <= (state_d != IDLE);
      end
   end

   // A start command already at its target has nothing to do, so it parks in IDLE.
   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      rate_d    = rate_q;
      cnt_d     = cnt_q;
      level_d   = fade_level;
      at_target = fade_dir ? (fade_level == 5'd0) : (fade_level == FADE_MAX);

      if (fade_start) begin
         if (at_target) begin
            state_d = IDLE;
         end else begin
            dir_d   = fade_dir;
            rate_d  = fade_rate;
            cnt_d   = '0;
            state_d = WAIT;
         end
      end else begin
         case (state_q)
            WAIT: begin
               if (frame_tick) begin
                  if (cnt_q == rate_q) state_d = STEP;
                  else                 cnt_d   = cnt_q + 4'd1;
               end
            end
            STEP: begin
               level_d = dir_q ? (fade_level - 5'd1) : (fade_level + 5'd1);
               if (level_d == (dir_q ? 5'd0 : FADE_MAX)) begin
                  state_d = IDLE;
               end else begin
                  cnt_d   = '0;
                  state_d = WAIT;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/video_out_fade.sv
// Video DAC output stage: TV/VGA index mux, palette CRAM lookup, global fade scaling
// and bit-replicated expansion to the DAC width.
module video_out_fade
   import video_pkg::*;
#(
   parameter int unsigned OUT_W  = 8,
   parameter int unsigned PAL_AW = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              c3,
   input  logic              vga_on,
   input  logic              tv_blank,
   input  logic              vga_blank,
   input  logic [1:0]        plex_sel_in,
   input  logic              tv_hires,
   input  logic              vga_hires,
   input  logic [3:0]        palsel,
   input  logic [7:0]        vplex_in,
   input  logic [7:0]        vgaplex,
   input  logic [PAL_AW-1:0] cram_addr_in,
   input  logic [15:0]       cram_data_in,
   input  logic              cram_we,
   input  logic              frame_tick,
   input  logic              fade_start,
   input  logic              fade_dir,
   input  logic [3:0]        fade_rate,
   output logic              fade_busy,
   output logic [4:0]        fade_level,
   output logic [OUT_W-1:0]  vred,
   output logic [OUT_W-1:0]  vgrn,
   output logic [OUT_W-1:0]  vblu,
   output logic              vdac_mode
);

   logic [7:0]        vplex_q;
   logic [7:0]        plex;
   logic              sel;
   logic              hires;
   logic              blank;
   logic [7:0]        idx;
   logic [PAL_AW-1:0] rd_addr;
   logic [15:0]       cram_q;
   logic              blank_d1;
   cram_word_t        word;
   logic [9:0]        rep_r, rep_g, rep_b;

   always_ff @(posedge clk) begin
      if (rst)     vplex_q <= '0;
      else if (c3) vplex_q <= vplex_in;
   end

   // Path select and hires nibble split into the palette bank
   always_comb begin
      plex    = vga_on ? vgaplex : vplex_q;
      sel     = vga_on ? plex_sel_in[0] : plex_sel_in[1];
      hires   = vga_on ? vga_hires : tv_hires;
      blank   = vga_on ? vga_blank : tv_blank;
      idx     = hires ? {palsel, (sel ? plex[3:0] : plex[7:4])} : plex;
      rd_addr = PAL_AW'(idx);
   end

   dpram #(
      .DATAWIDTH (16),
      .ADDRWIDTH (PAL_AW)
   ) u_cram (
      .clk    (clk),
      .we_a   (cram_we),
      .addr_a (cram_addr_in),
      .data_a (cram_data_in),
      .addr_b (rd_addr),
      .q_b    (cram_q)
   );

   video_fade_ctrl u_fade (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .fade_start (fade_start),
      .fade_dir   (fade_dir),
      .fade_rate  (fade_rate),
      .fade_busy  (fade_busy),
      .fade_level (fade_level)
   );

   always_ff @(posedge clk) begin
      if (rst) blank_d1 <= 1'b0;
      else     blank_d1 <= blank;
   end

   // Scale then replicate MSB-first; the top OUT_W bits of {s, s} feed the DAC
   always_comb begin
      word  = cram_word_t'(cram_q);
      rep_r = {2{scale_ch(word.r, fade_level)}};
      rep_g = {2{scale_ch(word.g, fade_level)}};
      rep_b = {2{scale_ch(word.b, fade_level)}};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vred      <= '0;
         vgrn      <= '0;
         vblu      <= '0;
         vdac_mode <= 1'b0;
      end else begin
         vred      <= blank_d1 ? '0 : rep_r[9 -: OUT_W];
         vgrn      <= blank_d1 ? '0 : rep_g[9 -: OUT_W];
         vblu      <= blank_d1 ? '0 : rep_b[9 -: OUT_W];
         vdac_mode <= word.mode;
      end
   end

endmodule
